// File: rtl/flusher_pkg.sv
// Shared definitions for the strip flusher: LCD command bytes, flush FSM states
// and strip geometry helpers.
package flusher_pkg;

  localparam int unsigned STRIP_W   = 4;
  localparam int unsigned BANK_AW   = 10;
  localparam int unsigned PIX_W     = 16;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CASET,
    ST_CA0H,
    ST_CA0L,
    ST_CA1H,
    ST_CA1L,
    ST_RASET,
    ST_RA0H,
    ST_RA0L,
    ST_RA1H,
    ST_RA1L,
    ST_RAMWR,
    ST_PIX_H,
    ST_PIX_L
  } flush_state_e;

  // Row-major pixel index {y, x} to strip address {x, y}
  function automatic logic [BANK_AW-1:0] pix_addr(input logic [BANK_AW-1:0] idx);
    return {idx[1:0], idx[BANK_AW-1:2]};
  endfunction

endpackage

// File: rtl/strip_bank_ram.sv
// Simple dual-port strip RAM, one write port and one registered read port
// (1-cycle read latency). Both strip banks live here with the bank bit as MSB.
module strip_bank_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/strip_flusher.sv
// Double-buffers renderer strips and streams each finished strip to the LCD as
// CASET/RASET/RAMWR plus pixel bytes. Optional perf counters: FLUSHER_PERF_CNT_EN.
module strip_flusher
  import flusher_pkg::*;
#(
  parameter int unsigned X_OFFSET = 0,
  parameter int unsigned Y_OFFSET = 0,
  parameter int unsigned STRIP_H  = 256,
  parameter int unsigned DRAIN    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] draw_wrdata,
  input  logic [9:0]  draw_wraddr,
  input  logic        draw_we,
  input  logic [6:0]  draw_id,
  input  logic        draw_next,
  output logic        draw_ready,
  output logic [7:0]  lcd_data,
  output logic        lcd_dc,
  output logic        lcd_valid,
  input  logic        lcd_ready
`ifdef FLUSHER_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] strip_cnt
`endif
);

  localparam int unsigned DRAIN_W = 8;
  localparam logic [BANK_AW-1:0] LAST_PIX = BANK_AW'(STRIP_W * STRIP_H - 1);
  localparam logic [15:0] Y0 = 16'(Y_OFFSET);
  localparam logic [15:0] Y1 = 16'(Y_OFFSET + STRIP_H - 1);

  // Swap control state
  logic               wr_bank_q;
  logic               pending_q;
  logic [6:0]         pend_id_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               err_q;

  // Flush FSM state
  flush_state_e       state_q;
  logic               fl_bank_q;
  logic [6:0]         fl_id_q;
  logic [BANK_AW-1:0] pix_q;
  logic [7:0]         lo_q;

  logic               handoff_c;
  logic               accept_c;
  logic               last_pix_c;
  logic [BANK_AW-1:0] rd_idx_c;
  logic [PIX_W-1:0]   rdata_c;
  logic [15:0]        x0_c;
  logic [15:0]        x1_c;

  assign handoff_c  = pending_q && (drain_q <= DRAIN_W'(1)) && (state_q == ST_IDLE);
  assign accept_c   = lcd_valid && lcd_ready;
  assign last_pix_c = (pix_q == LAST_PIX);
  assign x0_c       = 16'(fl_id_q) * 16'(STRIP_W) + 16'(X_OFFSET);
  assign x1_c       = x0_c + 16'(STRIP_W - 1);

  // Header phases read pixel 0; pixel phases read one pixel ahead of the bus,
  // so the RAM output register already holds the next word when PIX_L retires.
  assign rd_idx_c = ((state_q == ST_PIX_H) || (state_q == ST_PIX_L))
                    ? BANK_AW'(pix_q + BANK_AW'(1)) : '0;

  strip_bank_ram #(
    .AW (BANK_AW + 1),
    .DW (PIX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (draw_we),
    .waddr_i ({wr_bank_q, draw_wraddr}),
    .wdata_i (draw_wrdata),
    .raddr_i ({fl_bank_q, pix_addr(rd_idx_c)}),
    .rdata_o (rdata_c)
  );

  // Swap control: drain window after draw_next, then bank handoff to the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      pending_q  <= 1'b0;
      pend_id_q  <= '0;
      drain_q    <= '0;
      err_q      <= 1'b0;
      draw_ready <= 1'b1;
    end else begin
      if (handoff_c) begin
        wr_bank_q  <= ~wr_bank_q;
        pending_q  <= 1'b0;
        draw_ready <= 1'b1;
      end else if (pending_q && (drain_q != '0)) begin
        drain_q <= drain_q - DRAIN_W'(1);
      end
      if (draw_next) begin
        if (pending_q) begin
          err_q <= 1'b1;
        end else begin
          pend_id_q  <= draw_id;
          pending_q  <= 1'b1;
          drain_q    <= DRAIN_W'(DRAIN);
          draw_ready <= 1'b0;
        end
      end
    end
  end

  // Flush FSM: state names the byte currently presented on the LCD bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fl_bank_q <= 1'b0;
      fl_id_q   <= '0;
      pix_q     <= '0;
      lo_q      <= '0;
      lcd_valid <= 1'b0;
      lcd_data  <= '0;
      lcd_dc    <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (handoff_c) begin
        fl_bank_q <= wr_bank_q;
        fl_id_q   <= pend_id_q;
        pix_q     <= '0;
        state_q   <= ST_CASET;
        lcd_valid <= 1'b1;
        lcd_data  <= CMD_CASET;
        lcd_dc    <= 1'b0;
      end
    end else if (accept_c) begin
      lcd_dc <= 1'b1;
      case (state_q)
        ST_CASET: begin state_q <= ST_CA0H;  lcd_data <= x0_c[15:8]; end
        ST_CA0H:  begin state_q <= ST_CA0L;  lcd_data <= x0_c[7:0];  end
        ST_CA0L:  begin state_q <= ST_CA1H;  lcd_data <= x1_c[15:8]; end
        ST_CA1H:  begin state_q <= ST_CA1L;  lcd_data <= x1_c[7:0];  end
        ST_CA1L: begin
          state_q  <= ST_RASET;
          lcd_data <= CMD_RASET;
          lcd_dc   <= 1'b0;
        end
        ST_RASET: begin state_q <= ST_RA0H;  lcd_data <= Y0[15:8]; end
        ST_RA0H:  begin state_q <= ST_RA0L;  lcd_data <= Y0[7:0];  end
        ST_RA0L:  begin state_q <= ST_RA1H;  lcd_data <= Y1[15:8]; end
        ST_RA1H:  begin state_q <= ST_RA1L;  lcd_data <= Y1[7:0];  end
        ST_RA1L: begin
          state_q  <= ST_RAMWR;
          lcd_data <= CMD_RAMWR;
          lcd_dc   <= 1'b0;
        end
        ST_RAMWR: begin
          state_q  <= ST_PIX_H;
          pix_q    <= '0;
          lcd_data <= rdata_c[15:8];
          lo_q     <= rdata_c[7:0];
        end
        ST_PIX_H: begin
          state_q  <= ST_PIX_L;
          lcd_data <= lo_q;
        end
        ST_PIX_L: begin
          if (last_pix_c) begin
            state_q   <= ST_IDLE;
            lcd_valid <= 1'b0;
            lcd_data  <= '0;
            lcd_dc    <= 1'b0;
          end else begin
            state_q  <= ST_PIX_H;
            pix_q    <= BANK_AW'(pix_q + BANK_AW'(1));
            lcd_data <= rdata_c[15:8];
            lo_q     <= rdata_c[7:0];
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          lcd_valid <= 1'b0;
          lcd_dc    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLUSHER_PERF_CNT_EN
  logic done_c;
  logic blocked_c;

  assign done_c    = accept_c && (state_q == ST_PIX_L) && last_pix_c;
  assign blocked_c = !draw_ready && (drain_q == '0);

  // Saturating perf counters: renderer-blocked cycles and completed flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      strip_cnt <= '0;
    end else begin
      if (blocked_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (done_c && (strip_cnt != '1)) begin
        strip_cnt <= strip_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_strip_flusher.sv
// Directed bench for strip_flusher: captures accepted LCD bytes and compares
// them against a strip model built from the same write patterns.
module tb_strip_flusher;

  localparam int DRAIN   = 3;
  localparam int HDR     = 11;
  localparam int STREAM  = HDR + 2 * 4 * 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] draw_wrdata;
  logic [9:0]  draw_wraddr;
  logic        draw_we;
  logic [6:0]  draw_id;
  logic        draw_next;
  logic        draw_ready;
  logic [7:0]  lcd_data;
  logic        lcd_dc;
  logic        lcd_valid;
  logic        lcd_ready;
`ifdef FLUSHER_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] strip_cnt;
`endif

  strip_flusher dut (
    .clk         (clk),
    .rst         (rst),
    .draw_wrdata (draw_wrdata),
    .draw_wraddr (draw_wraddr),
    .draw_we     (draw_we),
    .draw_id     (draw_id),
    .draw_next   (draw_next),
    .draw_ready  (draw_ready),
    .lcd_data    (lcd_data),
    .lcd_dc      (lcd_dc),
    .lcd_valid   (lcd_valid),
    .lcd_ready   (lcd_ready)
`ifdef FLUSHER_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .strip_cnt   (strip_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] cap_q[$];
  int   stab_viol = 0;
  bit   hold_seen = 0;
  logic [7:0] hold_data;
  logic hold_dc;
  bit   rnd_ready = 0;
  bit   meas = 0;
  int   low_cnt = 0;

  // Byte capture and hold-stability watch on the LCD side
  always @(posedge clk) begin
    if (rst) begin
      hold_seen = 0;
    end else begin
      if (hold_seen && (lcd_valid !== 1'b1 || lcd_data !== hold_data || lcd_dc !== hold_dc))
        stab_viol++;
      if (lcd_valid && lcd_ready) cap_q.push_back({lcd_dc, lcd_data});
      hold_seen = lcd_valid && !lcd_ready;
      hold_data = lcd_data;
      hold_dc   = lcd_dc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) lcd_ready = ($urandom_range(9) < 3);
    if (meas && !draw_ready) low_cnt++;
  endtask

  function automatic logic [15:0] pix_val(input logic [7:0] seed, input logic [9:0] idx);
    logic [7:0] x;
    x = 8'(idx[1:0]);
    return {x + seed, idx[9:2]};
  endfunction

  task automatic write_strip(input logic [7:0] seed);
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) begin
      a = 10'(i);
      draw_we     = 1'b1;
      draw_wraddr = a;
      draw_wrdata = pix_val(seed, {a[7:0], a[9:8]});
      step();
    end
    draw_we = 1'b0;
  endtask

  task automatic pulse_next(input logic [6:0] id);
    draw_next = 1'b1;
    draw_id   = id;
    step();
    draw_next = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget, output int cycles);
    cycles = 0;
    while (cap_q.size() < n && cycles < budget) begin
      step();
      cycles++;
    end
    chk({tag, "_timeout"}, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic wait_ready(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (draw_ready !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    chk({tag, "_ready_timeout"}, 32'(draw_ready), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int off, input logic [6:0] id,
                              input logic [7:0] seed, input bit chk_pix,
                              input bit ovr, input logic [15:0] ovr_val);
    logic [8:0]  hdr [HDR];
    logic [15:0] x0, x1, pv;
    int bad;
    x0 = 16'(id) * 16'd4;
    x1 = x0 + 16'd3;
    hdr = '{{1'b0, 8'h2A}, {1'b1, x0[15:8]}, {1'b1, x0[7:0]}, {1'b1, x1[15:8]},
            {1'b1, x1[7:0]}, {1'b0, 8'h2B}, {1'b1, 8'h00}, {1'b1, 8'h00},
            {1'b1, 8'h00}, {1'b1, 8'hFF}, {1'b0, 8'h2C}};
    for (int i = 0; i < HDR; i++)
      chk($sformatf("%s_hdr%0d", tag, i), 32'(cap_q[off+i]), 32'(hdr[i]));
    if (chk_pix) begin
      bad = 0;
      for (int p = 0; p < 1024; p++) begin
        pv = pix_val(seed, 10'(p));
        if (ovr && p == 1023) pv = ovr_val;
        if (cap_q[off+HDR+2*p] !== {1'b1, pv[15:8]} || cap_q[off+HDR+1+2*p] !== {1'b1, pv[7:0]})
          bad++;
      end
      chk({tag, "_pix_errs"}, 32'(bad), 32'd0);
      chk({tag, "_last_pair"}, 32'({cap_q[off+STREAM-2], cap_q[off+STREAM-1]}),
          32'({1'b1, pv[15:8], 1'b1, pv[7:0]}));
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; draw_wrdata = '0; draw_wraddr = '0; draw_we = 1'b0;
    draw_id = '0; draw_next = 1'b0; lcd_ready = 1'b1;
    step(); step();
    chk("rst_ready", 32'(draw_ready), 32'd1);
    chk("rst_valid", 32'(lcd_valid), 32'd0);
    chk("rst_data",  32'(lcd_data), 32'd0);
    chk("rst_dc",    32'(lcd_dc), 32'd0);
    chk("rst_err",   32'(dut.err_q), 32'd0);
    rst = 1'b0;
    step();

    // Basic strip, id 5, ready always high
    write_strip(8'd0);
    pulse_next(7'd5);
    chk("t1_ready_drop", 32'(draw_ready), 32'd0);
    cyc = 1;
    while (draw_ready !== 1'b1 && cyc < 50) begin step(); cyc++; end
    chk("t1_ready_rise", 32'(cyc), 32'(DRAIN + 1));
    wait_bytes("t1", STREAM, 5000, cyc);
    chk("t1_cycles", 32'(cyc), 32'(STREAM));
    step();
    chk("t1_len", 32'(cap_q.size()), 32'(STREAM));
    chk("t1_idle_valid", 32'(lcd_valid), 32'd0);
    check_stream("t1", 0, 7'd5, 8'd0, 1'b1, 1'b0, 16'h0);
    cap_q.delete();

    // Back-to-back strips: second strip rendered while first flushes
    write_strip(8'd1);
    pulse_next(7'd0);
    wait_ready("t2a", 50, cyc);
    write_strip(8'd2);
    pulse_next(7'd1);
    for (int i = 0; i < DRAIN + 1; i++) step();
    chk("t2_held_low", 32'(draw_ready), 32'd0);
    wait_ready("t2b", 3000, cyc);
    chk("t2_rise_at_end", 32'(cap_q.size()), 32'(STREAM));
    wait_bytes("t2", 2 * STREAM, 5000, cyc);
    step();
    check_stream("t2s0", 0, 7'd0, 8'd1, 1'b1, 1'b0, 16'h0);
    check_stream("t2s1", STREAM, 7'd1, 8'd2, 1'b1, 1'b0, 16'h0);
    cap_q.delete();

    // Random 30% lcd_ready, last strip id
    rnd_ready = 1;
    write_strip(8'd3);
    pulse_next(7'd79);
    wait_bytes("t3", STREAM, 30000, cyc);
    rnd_ready = 0;
    lcd_ready = 1'b1;
    step(); step();
    chk("t3_len", 32'(cap_q.size()), 32'(STREAM));
    chk("t3_hold_stable", 32'(stab_viol), 32'd0);
    check_stream("t3", 0, 7'd79, 8'd3, 1'b1, 1'b0, 16'h0);
    cap_q.delete();

    // Write in the last drain cycle lands in the flushed strip; one later does not
    write_strip(8'd4);
    pulse_next(7'd2);
    step(); step();
    draw_we = 1'b1; draw_wraddr = 10'h3FF; draw_wrdata = 16'hBEEF;
    step();
    draw_wrdata = 16'h1234;
    step();
    draw_we = 1'b0;
    wait_bytes("t4", STREAM, 5000, cyc);
    step();
    check_stream("t4", 0, 7'd2, 8'd4, 1'b1, 1'b1, 16'hBEEF);
    cap_q.delete();

    // Reset in the middle of the pixel stream
    write_strip(8'd5);
    pulse_next(7'd7);
    wait_bytes("t5a", 30, 200, cyc);
    rst = 1'b1;
    step();
    chk("t5_rst_valid", 32'(lcd_valid), 32'd0);
    chk("t5_rst_ready", 32'(draw_ready), 32'd1);
    rst = 1'b0;
    cap_q.delete();
    step();
    write_strip(8'd6);
    pulse_next(7'd9);
    wait_bytes("t5b", STREAM, 5000, cyc);
    step();
    chk("t5_len", 32'(cap_q.size()), 32'(STREAM));
    check_stream("t5", 0, 7'd9, 8'd6, 1'b1, 1'b0, 16'h0);
    cap_q.delete();

    // Second draw_next while pending is ignored and flagged
    pulse_next(7'd3);
    pulse_next(7'd4);
    chk("t6_err", 32'(dut.err_q), 32'd1);
    wait_bytes("t6", STREAM, 5000, cyc);
    step();
    chk("t6_len", 32'(cap_q.size()), 32'(STREAM));
    check_stream("t6", 0, 7'd3, 8'd0, 1'b0, 1'b0, 16'h0);
    cap_q.delete();

`ifdef FLUSHER_PERF_CNT_EN
    // Two strips behind a stalled LCD: counters vs. measured blocked cycles
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    cap_q.delete();
    step();
    lcd_ready = 1'b0;
    low_cnt = 0;
    meas = 1;
    pulse_next(7'd0);
    for (int i = 0; i < 9; i++) step();
    pulse_next(7'd1);
    for (int i = 0; i < 90; i++) step();
    lcd_ready = 1'b1;
    wait_bytes("t7", 2 * STREAM, 8000, cyc);
    step(); step();
    meas = 0;
    chk("t7_strip_cnt", 32'(strip_cnt), 32'd2);
    chk("t7_stall_cnt", stall_cnt, 32'(low_cnt - 2 * DRAIN));
    chk("t7_blocked_nonzero", 32'(low_cnt > 2 * DRAIN + 100), 32'd1);
    cap_q.delete();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
